// File: rtl/cnt_cmd_seq_pkg.sv
// Shared opcodes, state encoding and default sizing for the counter command sequencer.
package cnt_cmd_seq_pkg;

  localparam int DIV_W_DEF = 8;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_CLR      = 3'd1;
  localparam logic [2:0] OP_LOAD     = 3'd2;
  localparam logic [2:0] OP_RUN_UP   = 3'd3;
  localparam logic [2:0] OP_RUN_DN   = 3'd4;
  localparam logic [2:0] OP_STOP     = 3'd5;
  localparam logic [2:0] OP_STEP     = 3'd6;
  localparam logic [2:0] OP_PINGPONG = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/cnt_cmd_seq_rate_prescaler.sv
// Free-running 0..div prescaler; terminal flags the last count of each en period.
module rate_prescaler
  import cnt_cmd_seq_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             terminal
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // A div lowered below cnt_q is simply passed by; the count wraps at 2^DIV_W.
  always_comb begin
    terminal = (cnt_q == div);
    cnt_d    = (restart || terminal) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cnt_cmd_seq.sv
// Command sequencer driving univ_bin_counter controls (clear/load/run/step/ping-pong).
// Optional wrap_cnt output enabled by defining CNT_CMD_SEQ_WRAPCNT_EN.
module cnt_cmd_seq
  import cnt_cmd_seq_pkg::*;
#(
  parameter int N     = 3,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [N-1:0]     cmd_data,
  input  logic [DIV_W-1:0] div,
  input  logic             max_tick,
  input  logic             min_tick,
  output logic             syn_clr,
  output logic             load,
  output logic             en,
  output logic             up,
  output logic [N-1:0]     d,
  output logic             running
`ifdef CNT_CMD_SEQ_WRAPCNT_EN
  ,
  output logic [7:0]       wrap_cnt
`endif
);

  state_t       state_q, state_d;
  logic         pp_q, pp_d;
  logic         up_q, up_d;
  logic         en_q, en_d;
  logic         syn_clr_q, syn_clr_d;
  logic         load_q, load_d;
  logic         running_q, running_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic [N-1:0] d_q, d_d;
  logic [N-1:0] cq_q, cq_d;
  logic         accept, restart, terminal, term_evt;
  logic         moving, at_max, at_min, step_pulse;

  always_comb begin
    accept  = cmd_valid && cmd_ready_q;
    restart = (state_q != ST_RUN) ||
              (accept && (cmd_op == OP_CLR || cmd_op == OP_LOAD || cmd_op == OP_RUN_UP ||
                          cmd_op == OP_RUN_DN || cmd_op == OP_PINGPONG));
  end

  rate_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .div      (div),
    .terminal (terminal)
  );

  always_comb begin
    state_d     = state_q;
    pp_d        = pp_q;
    up_d        = up_q;
    d_d         = d_q;
    en_d        = 1'b0;
    syn_clr_d   = 1'b0;
    load_d      = 1'b0;
    step_pulse  = 1'b0;

    // Track the counter value it will hold after this edge. When a pulse is
    // moving the counter right now, the ticks describe the old value and a
    // bounce decided on them would come one count too late (wrap at div=0).
    cq_d = cq_q;
    if (syn_clr_q)   cq_d = '0;
    else if (load_q) cq_d = d_q;
    else if (en_q)   cq_d = up_q ? cq_q + 1'b1 : cq_q - 1'b1;
    moving = syn_clr_q || load_q || en_q;
    at_max = moving ? (cq_d == '1) : max_tick;
    at_min = moving ? (cq_d == '0) : min_tick;

    term_evt = (state_q == ST_RUN) && terminal;
    if (term_evt) begin
      en_d = 1'b1;
      if (pp_q) begin
        if (up_q && at_max)       up_d = 1'b0;
        else if (!up_q && at_min) up_d = 1'b1;
      end
    end

    if (accept) begin
      case (cmd_op)
        OP_CLR: begin
          syn_clr_d = 1'b1;
          en_d      = 1'b0;
        end
        OP_LOAD: begin
          load_d = 1'b1;
          d_d    = cmd_data;
          en_d   = 1'b0;
        end
        OP_RUN_UP: begin
          up_d    = 1'b1;
          pp_d    = 1'b0;
          state_d = ST_RUN;
        end
        OP_RUN_DN: begin
          up_d    = 1'b0;
          pp_d    = 1'b0;
          state_d = ST_RUN;
        end
        OP_PINGPONG: begin
          pp_d    = 1'b1;
          state_d = ST_RUN;
        end
        OP_STOP: begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          up_d    = up_q;
        end
        OP_STEP: begin
          if (state_q == ST_IDLE) begin
            en_d       = 1'b1;
            step_pulse = 1'b1;
          end
        end
        default: ;
      endcase
    end

    running_d   = (state_d == ST_RUN);
    cmd_ready_d = !(syn_clr_d || load_d || step_pulse);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pp_q        <= 1'b0;
      up_q        <= 1'b1;
      d_q         <= '0;
      cq_q        <= '0;
      en_q        <= 1'b0;
      syn_clr_q   <= 1'b0;
      load_q      <= 1'b0;
      running_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pp_q        <= pp_d;
      up_q        <= up_d;
      d_q         <= d_d;
      cq_q        <= cq_d;
      en_q        <= en_d;
      syn_clr_q   <= syn_clr_d;
      load_q      <= load_d;
      running_q   <= running_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign syn_clr   = syn_clr_q;
  assign load      = load_q;
  assign en        = en_q;
  assign up        = up_q;
  assign d         = d_q;
  assign running   = running_q;

`ifdef CNT_CMD_SEQ_WRAPCNT_EN
  logic [7:0] wrap_q, wrap_d;

  always_comb begin
    wrap_d = wrap_q;
    if (en_q && !pp_q && ((up_q && max_tick) || (!up_q && min_tick)) && wrap_q != 8'hFF)
      wrap_d = wrap_q + 8'd1;
    if (accept && cmd_op == OP_CLR)
      wrap_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wrap_q <= '0;
    else        wrap_q <= wrap_d;
  end

  assign wrap_cnt = wrap_q;
`endif

endmodule

// File: tb/tb_cnt_cmd_seq.sv
// Scoreboard bench for cnt_cmd_seq closing the loop through a small counter model.
module tb_cnt_cmd_seq;
  import cnt_cmd_seq_pkg::*;

  localparam int N     = 3;
  localparam int DIV_W = 8;
  localparam int MODV  = 1 << N;
  localparam logic [2:0] K_CLR = 3'b100;
  localparam logic [2:0] K_LD  = 3'b010;
  localparam logic [2:0] K_EN  = 3'b001;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic [N-1:0]     cmd_data = '0;
  logic [DIV_W-1:0] div = '0;
  logic             max_tick, min_tick;
  logic             syn_clr, load, en, up;
  logic [N-1:0]     d;
  logic             running;
`ifdef CNT_CMD_SEQ_WRAPCNT_EN
  logic [7:0]       wrap_cnt;
`endif

  cnt_cmd_seq #(.N(N), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .div(div), .max_tick(max_tick),
    .min_tick(min_tick), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .running(running)
`ifdef CNT_CMD_SEQ_WRAPCNT_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  // The counter being sequenced.
  logic [N-1:0] cq;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cq <= '0;
    else if (syn_clr) cq <= '0;
    else if (load)    cq <= d;
    else if (en)      cq <= up ? cq + 1'b1 : cq - 1'b1;
  end
  assign max_tick = (cq == '1);
  assign min_tick = (cq == '0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    logic [2:0] kind;
    logic     up;
    int       q;
    int       dv;
    logic     ready;
  } item_t;
  typedef struct {
    string name;
    int    act;
    int    exp;
  } dchk_t;

  item_t exp_q[$];
  dchk_t dq[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  item_t it;
  dchk_t dc;
  logic  ok;

  // Monitor: every control pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (mon_en && (syn_clr || load || en)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse cyc=%0d got kind=%b q=%0d, none expected", cyc, {syn_clr, load, en}, cq);
      end else begin
        it = exp_q.pop_front();
        ok = (cyc == it.cyc) && ({syn_clr, load, en} == it.kind) && (cmd_ready == it.ready);
        if (it.kind == K_EN) ok = ok && (up == it.up) && (int'(cq) == it.q);
        if (it.kind == K_LD) ok = ok && (int'(d) == it.dv);
        if (!ok) begin
          errors++;
          $display("FAIL pulse got cyc=%0d kind=%b up=%0d q=%0d d=%0d rdy=%0d expected cyc=%0d kind=%b up=%0d q=%0d d=%0d rdy=%0d",
                   cyc, {syn_clr, load, en}, up, cq, d, cmd_ready,
                   it.cyc, it.kind, it.up, it.q, it.dv, it.ready);
        end
      end
    end
    while (dq.size() > 0) begin
      dc = dq.pop_front();
      checks++;
      if (dc.act != dc.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", dc.name, dc.act, dc.exp);
      end
    end
  end

  // Reference model state: counter value, direction, bounce mode.
  int mq = 0;
  bit mup = 1'b1;
  bit mpp = 1'b0;

  task automatic dchk(input string nm, input int act, input int exp);
    dchk_t x;
    x.name = nm; x.act = act; x.exp = exp;
    dq.push_back(x);
  endtask

  task automatic push_item(input int c, input logic [2:0] k, input logic u,
                           input int q, input int dv, input logic r);
    item_t x;
    x.cyc = c; x.kind = k; x.up = u; x.q = q; x.dv = dv; x.ready = r;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [N-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    dchk("accept_ready", int'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [2:0] op, input int data);
    int a;
    a = cyc + 1;
    case (op)
      OP_CLR:  begin push_item(a, K_CLR, 1'b0, 0, 0, 1'b0); mq = 0; end
      OP_LOAD: begin push_item(a, K_LD, 1'b0, 0, data, 1'b0); mq = data; end
      OP_STEP: begin
        push_item(a, K_EN, mup, mq, 0, 1'b0);
        mq = mup ? (mq + 1) % MODV : (mq + MODV - 1) % MODV;
      end
      default: ;
    endcase
    issue(op, data[N-1:0]);
    idle(1);
  endtask

  // Run for k en periods plus off cycles, then STOP; optionally a CLR/LOAD mid-run.
  task automatic run_seg(input logic [2:0] op, input int dv, input int k,
                         input int off, input bit mid_en);
    int a, s, len, l, anchor, mdata;
    logic [2:0] mop;
    div   = dv[DIV_W-1:0];
    len   = (dv + 1) * k + off;
    a     = cyc + 1;
    s     = a + len;
    l     = -1;
    if (mid_en && len >= 4) l = a + int'($urandom_range(1, len - 2));
    mop   = ($urandom_range(0, 1) == 1) ? OP_CLR : OP_LOAD;
    mdata = int'($urandom_range(0, MODV - 1));
    case (op)
      OP_RUN_UP: begin mup = 1'b1; mpp = 1'b0; end
      OP_RUN_DN: begin mup = 1'b0; mpp = 1'b0; end
      default:   mpp = 1'b1;
    endcase
    anchor = a;
    for (int e = a + 1; e < s; e++) begin
      if (e == l) begin
        if (mop == OP_CLR) begin push_item(e, K_CLR, 1'b0, 0, 0, 1'b0); mq = 0; end
        else begin push_item(e, K_LD, 1'b0, 0, mdata, 1'b0); mq = mdata; end
        anchor = e;
      end else if ((e - anchor) % (dv + 1) == 0) begin
        if (mpp) begin
          if (mup && mq == MODV - 1) mup = 1'b0;
          else if (!mup && mq == 0)  mup = 1'b1;
        end
        push_item(e, K_EN, mup, mq, 0, 1'b1);
        mq = mup ? (mq + 1) % MODV : (mq + MODV - 1) % MODV;
      end
    end
    issue(op, '0);
    dchk("running_on", int'(running), 1);
    for (int e = a + 1; e <= s; e++) begin
      if (e == s)          issue(OP_STOP, '0);
      else if (e == l)     issue(mop, mdata[N-1:0]);
      else if (e == a + 1) issue(OP_STEP, '0);
      else                 idle(1);
    end
    dchk("running_off", int'(running), 0);
    idle(2);
  endtask

  initial begin
    int r, dv;
    logic [2:0] rop;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    dchk("rst_en", int'(en), 0);
    dchk("rst_up", int'(up), 1);
    dchk("rst_d", int'(d), 0);
    dchk("rst_running", int'(running), 0);
    dchk("rst_ready", int'(cmd_ready), 1);
    dchk("rst_syn_clr", int'(syn_clr), 0);
    dchk("rst_load", int'(load), 0);
    idle(1);

    // Asynchronous reset in the middle of a fast down-count.
    issue(OP_LOAD, 3'd5);
    idle(1);
    div = '0;
    issue(OP_RUN_DN, '0);
    idle(5);
    #2;
    reset = 1'b0;
    #1;
    dchk("arst_en", int'(en), 0);
    dchk("arst_up", int'(up), 1);
    dchk("arst_d", int'(d), 0);
    dchk("arst_running", int'(running), 0);
    dchk("arst_ready", int'(cmd_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(3);
    dchk("q_after_rst", int'(cq), 0);
    dchk("en_after_rst", int'(en), 0);

`ifdef CNT_CMD_SEQ_WRAPCNT_EN
    div = '0;
    issue(OP_RUN_UP, '0);
    idle(19);
    issue(OP_STOP, '0);
    dchk("wrap_cnt_run", int'(wrap_cnt), 2);
    issue(OP_CLR, '0);
    dchk("wrap_cnt_clr", int'(wrap_cnt), 0);
    idle(2);
`endif
    mq = 0; mup = 1'b1; mpp = 1'b0;
    mon_en = 1'b1;

    // Directed: bounce from 5, paced run, single steps.
    do_cmd(OP_LOAD, 5);
    run_seg(OP_PINGPONG, 0, 20, 0, 1'b0);
    do_cmd(OP_LOAD, 3);
    do_cmd(OP_CLR, 0);
    run_seg(OP_RUN_UP, 3, 4, 1, 1'b0);
    do_cmd(OP_CLR, 0);
    run_seg(OP_RUN_DN, 0, 1, 0, 1'b0);
    do_cmd(OP_STEP, 0);
    dchk("d_held", int'(d), 3);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 5));
      case (r)
        0: do_cmd(OP_CLR, 0);
        1: do_cmd(OP_LOAD, int'($urandom_range(0, MODV - 1)));
        2: do_cmd(OP_STEP, 0);
        3: do_cmd(OP_NOP, 0);
        default: begin
          dv = int'($urandom_range(0, 4));
          case ($urandom_range(0, 2))
            0:       rop = OP_RUN_UP;
            1:       rop = OP_RUN_DN;
            default: rop = OP_PINGPONG;
          endcase
          run_seg(rop, dv, int'($urandom_range(1, 5)), int'($urandom_range(0, dv)), 1'b1);
        end
      endcase
    end

    idle(2);
    dchk("leftover_expected", exp_q.size(), 0);
    dchk("final_q", int'(cq), mq);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_cmd_seq.md
Name: cnt_cmd_seq

Overview:
- Upstream command sequencer for the universal binary counter (univ_bin_counter).
- Takes opcodes over a valid/ready handshake and a programmable rate divisor, and drives the counter's syn_clr/load/en/up/d control inputs.
- Reads back max_tick/min_tick to support ping-pong (bounce) counting, so a test or host never hand-sequences the counter controls.

Parameters:
N, 3, counter width; width of d and cmd_data.
DIV_W, 8, width of rate divisor and internal prescaler.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  reset, asynchronous, active-low.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command this cycle.
cmd_op  in  3  opcode: 0 NOP, 1 CLR, 2 LOAD, 3 RUN_UP, 4 RUN_DN, 5 STOP, 6 STEP, 7 PINGPONG.
cmd_data  in  N  load value for LOAD.
div  in  DIV_W  en period minus one while running; sampled live.
max_tick  in  1  from counter, q==all ones.
min_tick  in  1  from counter, q==0.
syn_clr  out  1  to counter, one-cycle clear pulse.
load  out  1  to counter, one-cycle load pulse.
en  out  1  to counter, count strobe.
up  out  1  to counter, direction (1=up).
d  out  N  to counter, load value.
running  out  1  high in RUN state.

Behaviour:
- All outputs are registered.
- Reset values: syn_clr=0, load=0, en=0, up=1, d=0, running=0, cmd_ready=1, prescaler=0, state=IDLE, pingpong mode flag=0.
- Accept rule: a command is accepted on a rising edge with cmd_valid && cmd_ready.
- cmd_ready is 0 only during the cycle a syn_clr, load or STEP-en pulse is high. Back-to-back pulse commands therefore land at most every 2 cycles.
- States: IDLE and RUN.
- CLR (any state): syn_clr=1 for the one cycle after accept; en=0 that cycle; state unchanged; prescaler restarts at 0.
- LOAD (any state): d<=cmd_data and load=1 for the one cycle after accept; en=0 that cycle; d holds until the next LOAD; prescaler restarts.
- RUN_UP / RUN_DN: up<=1/0, pingpong flag<=0, state<=RUN, prescaler<=0.
- PINGPONG: state<=RUN, pingpong flag<=1, up unchanged, prescaler<=0.
- STOP: state<=IDLE and en<=0 from the next cycle; up and d held.
- STEP: in IDLE, en=1 for exactly one cycle in the current direction. In RUN, STEP is accepted and ignored.
- NOP: accepted; no effect.
- Prescaler in RUN:
  - Counts 0..div.
  - At each edge where prescaler==div (terminal), the prescaler returns to 0 and en=1 for the following cycle; otherwise en=0.
  - en period is div+1 cycles; div=0 gives en high continuously.
  - First en is high div+1 cycles after the accept edge.
  - If div is changed below the current prescaler value, the prescaler wraps naturally at 2^DIV_W without hanging. A change takes effect on the next terminal.
- Ping-pong reversal, evaluated at a terminal edge with pingpong flag=1:
  - if up && max_tick, then up<=0 and en<=1 in the same edge;
  - if !up && min_tick, then up<=1 and en<=1.
  - Result: counter sequence for N=3 is 0..7,6..0,1..., with no wrap and no dwell.
- Simultaneous events: a CLR/LOAD accept coinciding with a terminal edge suppresses that en; the CLR/LOAD pulse has priority.
- Non-pingpong RUN wraps naturally through the counter.
- Reset mid-operation: outputs return asynchronously to reset values; any pending pulse is lost.

Optional Feature:
CNT_CMD_SEQ_WRAPCNT_EN
- Defined: adds output port wrap_cnt[7:0]. It increments on each edge where en==1 and ((up && max_tick) || (!up && min_tick)), i.e. a counter wrap. It saturates at 255, is cleared by CLR and reset, and never counts in ping-pong mode.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package cnt_cmd_seq_pkg holds:
  - opcode localparams OP_NOP..OP_PINGPONG;
  - state encoding ST_IDLE/ST_RUN;
  - default DIV_W.
- One sub-module, rate_prescaler (DIV_W): restart input, div input, terminal output.
- The FSM, handshake and pulse generation stay in cnt_cmd_seq.

Test Plan:
- Reset low mid-run with div=0 -> en=0, up=1, d=0, running=0, cmd_ready=1 immediately (asynchronous); after release, counter q stays at 0.
- LOAD cmd_data=3 in IDLE -> load=1 and d=3 for one cycle; cmd_ready=0 that cycle; counter q=3; then CLR -> syn_clr one cycle, q=0.
- RUN_UP with div=3 -> en high 1 cycle in every 4, first en 4 cycles after accept; q steps 0,1,2... once per 4 cycles; STOP -> en stays 0, q frozen.
- PINGPONG with div=0 from q=5, up=1 -> q=6,7,6,5,...,0,1; up falls on the edge where q=7 and rises where q=0; max_tick high exactly one cycle per bounce.
- STEP in IDLE with up=0 from q=0 -> single en pulse, q=7; STEP while running -> no extra en.
- With CNT_CMD_SEQ_WRAPCNT_EN: RUN_UP, div=0, run 20 cycles from q=0 -> wrap_cnt=2; CLR -> wrap_cnt=0.
